// File: rtl/uart_instr_loader_if.sv
// Instruction read port and loader status between uart_instr_loader and the fetch mux.
// The slave side is the loader; the master side is the instruction consumer.
interface uart_instr_loader_if #(
   parameter int DEPTH_WORDS = 128
);
   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   logic [8:0]      instr_addr;
   logic [31:0]     instr;
   logic            byte_valid;
   logic [7:0]      rx_byte;
   logic [ADDR_W:0] words_loaded;
   logic            load_done;
   logic            frame_err;

   modport slave (
      input  instr_addr,
      output instr, byte_valid, rx_byte, words_loaded, load_done, frame_err
   );

   modport master (
      output instr_addr,
      input  instr, byte_valid, rx_byte, words_loaded, load_done, frame_err
   );
endinterface

// File: rtl/uart_instr_loader.sv
// 8N1 UART receiver that packs bytes little-endian into 32-bit words and serves
// them through a combinational read port; unloaded words read as NOP.
module uart_instr_loader #(
   parameter int CLK_HZ      = 50000000,
   parameter int BAUD        = 115200,
   parameter int DEPTH_WORDS = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   uart_instr_loader_if.slave bus
);
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int ADDR_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W  = $clog2(CPB);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);
   localparam logic [31:0]      NOP  = 32'h0000_0013;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t            state, state_nxt;
   logic [1:0]        sync_q;
   logic              rx_s;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic [7:0]        rx_byte;
   logic              byte_valid;
   logic              frame_err;
   logic [1:0]        byte_pos;
   logic [23:0]       word;
   logic [ADDR_W:0]   words_loaded;
   logic              load_done;
   logic              cnt_clr, bit_smp, byte_ok, frame_bad, wr_en;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       mem [DEPTH_WORDS];
   logic              unused_addr;

   // Synchronizer idles high so reset release never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], uart_rx};
   end
   assign rx_s = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      bit_smp   = 1'b0;
      byte_ok   = 1'b0;
      frame_bad = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) state_nxt = START;
         end
         START: if (cnt == HALF) begin
            cnt_clr   = 1'b1;
            state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt == FULL) begin
            cnt_clr = 1'b1;
            bit_smp = 1'b1;
            if (bit_idx == 3'd7) state_nxt = STOP;
         end
         STOP: if (cnt == FULL) begin
            cnt_clr = 1'b1;
            if (rx_s) begin
               byte_ok   = 1'b1;
               state_nxt = IDLE;
            end else begin
               frame_bad = 1'b1;
               state_nxt = BRK;
            end
         end
         BRK: begin
            cnt_clr = 1'b1;
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load_done = (words_loaded == (ADDR_W + 1)'(DEPTH_WORDS));
   assign wr_en     = byte_ok && !load_done && (byte_pos == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         rx_byte      <= '0;
         byte_valid   <= 1'b0;
         frame_err    <= 1'b0;
         byte_pos     <= '0;
         word         <= '0;
         words_loaded <= '0;
      end else begin
         cnt        <= cnt_clr ? '0 : cnt + 1'b1;
         byte_valid <= byte_ok;
         if (state != DATA) bit_idx <= '0;
         else if (bit_smp)  bit_idx <= bit_idx + 1'b1;
         if (bit_smp)   shift[bit_idx] <= rx_s;
         if (frame_bad) frame_err <= 1'b1;
         if (byte_ok) begin
            rx_byte <= shift;
            // Once full, bytes are still reported but no longer assembled
            if (!load_done) begin
               byte_pos <= byte_pos + 1'b1;
               if (byte_pos == 2'd3) words_loaded <= words_loaded + 1'b1;
               else                  word[8*byte_pos +: 8] <= shift;
            end
         end
      end
   end

   // RAM is deliberately not reset; the words_loaded guard hides stale contents
   always_ff @(posedge clk) begin
      if (wr_en) mem[words_loaded[ADDR_W-1:0]] <= {shift, word};
   end

   assign idx = bus.instr_addr[ADDR_W+1:2];
   assign unused_addr = ^bus.instr_addr;

   assign bus.instr        = ({1'b0, idx} < words_loaded) ? mem[idx] : NOP;
   assign bus.byte_valid   = byte_valid;
   assign bus.rx_byte      = rx_byte;
   assign bus.words_loaded = words_loaded;
   assign bus.load_done    = load_done;
   assign bus.frame_err    = frame_err;
endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader at 16 clocks per bit and a 4-word buffer.
module tb_uart_instr_loader;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   pulses = 0;
   int   p0;
   logic [31:0] rd;

   uart_instr_loader_if #(.DEPTH_WORDS(4)) bus ();

   uart_instr_loader #(.CLK_HZ(16), .BAUD(1), .DEPTH_WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.byte_valid) pulses++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_bits);
      uart_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(CPB);
      end
      uart_rx = stop_lvl;
      idle(CPB * stop_bits);
      uart_rx = 1'b1;
      idle(CPB);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1, 1);
   endtask

   task automatic rd_word(input logic [8:0] a, output logic [31:0] d);
      bus.instr_addr = a;
      #1 d = bus.instr;
   endtask

   task automatic do_reset;
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fill_exp [4];
      fill_exp[0] = 32'h0403_0201;
      fill_exp[1] = 32'h0807_0605;
      fill_exp[2] = 32'h0C0B_0A09;
      fill_exp[3] = 32'h100F_0E0D;
      bus.instr_addr = '0;

      // Reset state
      idle(2);
      do_reset;
      rd_word(9'd0, rd);
      chk("rst_instr0", rd, 32'h13);
      chk("rst_words", 32'(bus.words_loaded), 0);
      chk("rst_done", 32'(bus.load_done), 0);
      chk("rst_ferr", 32'(bus.frame_err), 0);
      chk("rst_rxbyte", 32'(bus.rx_byte), 0);
      chk("rst_bvalid", 32'(bus.byte_valid), 0);

      // One word, little-endian
      p0 = pulses;
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
      chk("w1_pulses", 32'(pulses - p0), 4);
      chk("w1_rxbyte", 32'(bus.rx_byte), 32'h00);
      chk("w1_words", 32'(bus.words_loaded), 1);
      rd_word(9'd0, rd); chk("w1_instr0", rd, 32'h0010_0513);
      rd_word(9'd4, rd); chk("w1_instr4", rd, 32'h13);
      rd_word(9'd3, rd); chk("w1_lowbits", rd, 32'h0010_0513);

      // Framing error with a long break, then a clean byte starting a fresh word
      do_reset;
      p0 = pulses;
      send_frame(8'hA5, 1'b0, 20);
      chk("fe_nopulse", 32'(pulses - p0), 0);
      chk("fe_flag", 32'(bus.frame_err), 1);
      chk("fe_words", 32'(bus.words_loaded), 0);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      chk("fe_pulses", 32'(pulses - p0), 4);
      chk("fe_sticky", 32'(bus.frame_err), 1);
      rd_word(9'd0, rd); chk("fe_instr0", rd, 32'h8877_6655);

      // Short low glitch on an idle line
      do_reset;
      p0 = pulses;
      uart_rx = 1'b0; idle(4); uart_rx = 1'b1; idle(3 * CPB);
      chk("gl_nopulse", 32'(pulses - p0), 0);
      chk("gl_ferr", 32'(bus.frame_err), 0);
      send_byte(8'h3C);
      chk("gl_recover", 32'(bus.rx_byte), 32'h3C);

      // Fill the buffer, then overflow with one byte
      do_reset;
      for (int k = 1; k <= 15; k++) send_byte(8'(k));
      chk("fill15_done", 32'(bus.load_done), 0);
      chk("fill15_words", 32'(bus.words_loaded), 3);
      rd_word(9'd12, rd); chk("fill15_instr3", rd, 32'h13);
      send_byte(8'h10);
      chk("fill_done", 32'(bus.load_done), 1);
      chk("fill_words", 32'(bus.words_loaded), 4);
      for (int w = 0; w < 4; w++) begin
         rd_word(9'(4 * w), rd);
         chk($sformatf("fill_instr%0d", w), rd, fill_exp[w]);
      end
      p0 = pulses;
      send_byte(8'hAA);
      chk("ovf_pulse", 32'(pulses - p0), 1);
      chk("ovf_rxbyte", 32'(bus.rx_byte), 32'hAA);
      chk("ovf_words", 32'(bus.words_loaded), 4);
      rd_word(9'd0, rd);  chk("ovf_instr0", rd, fill_exp[0]);
      rd_word(9'd12, rd); chk("ovf_instr3", rd, fill_exp[3]);

      // Reset mid-byte after two bytes of a word
      do_reset;
      send_byte(8'hDE); send_byte(8'hAD);
      uart_rx = 1'b0; idle(CPB); uart_rx = 1'b1; idle(40);
      do_reset;
      chk("mr_words", 32'(bus.words_loaded), 0);
      rd_word(9'd0, rd); chk("mr_stale", rd, 32'h13);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      rd_word(9'd0, rd); chk("mr_instr0", rd, 32'h4433_2211);
      chk("mr_words1", 32'(bus.words_loaded), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
